// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM state codes, port ids
// and the default watchdog limit.
package mem_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Requester ids, also used as the grant value
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Default number of BUSY cycles tolerated without a RAM ack
  localparam int TIMEOUT_DEF = 15;

  // Last watchdog count before an access is aborted
  function automatic logic [7:0] wd_last(input int timeout);
    return 8'(timeout - 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way arbiter. Picks a winner from the live requests; when both ports
// request it either alternates (round-robin) or always favours port 0.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       rr_en,
  output logic       winner
);

  logic last_r;
  logic winner_s;

  // Choose the winner from the current requests and the last port served
  always_comb begin
    winner_s = PORT0;
    case (req)
      2'b01: winner_s = PORT0;
      2'b10: winner_s = PORT1;
      2'b11: begin
        if (rr_en) begin
          winner_s = ~last_r;
        end else begin
          winner_s = PORT0;
        end
      end
      default: winner_s = PORT0;
    endcase
  end

  // Remember who was served last; reset value lets port 0 win first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= PORT1;
    end else if (update) begin
      last_r <= winner_s;
    end
  end

  assign winner = winner_s;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle RAM between two requesters. The winning request is
// latched so the RAM sees a stable address/data for the whole access, and a
// watchdog aborts accesses the RAM never acknowledges.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RR_EN   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ack,
  output logic          p0_stall,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ack,
  output logic          p1_stall,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ack,
  output logic          grant,
  output logic          timeout_err
);

  localparam logic [7:0] WD_LAST = wd_last(TIMEOUT);

  logic [1:0]    state_r;
  logic [1:0]    next_state_s;
  logic [7:0]    wdog_r;
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          grant_r;
  logic          terr_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;
  logic [1:0]    req_s;
  logic          winner_s;
  logic          grant_en_s;
  logic          wd_exp_s;

  assign req_s      = {p1_req, p0_req};
  assign grant_en_s = (state_r == IDLE) && (req_s != 2'b00);
  assign wd_exp_s   = (wdog_r == WD_LAST);

  arb_rr2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_s),
    .update (grant_en_s),
    .rr_en  (RR_EN != 0),
    .winner (winner_s)
  );

  // State register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: grant on any request, finish on ack or watchdog expiry
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s != 2'b00) begin
          next_state_s = BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack || wd_exp_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: RAM strobes only in BUSY, owner ack only in DONE
  always_comb begin
    mem_cs = 1'b0;
    mem_we = 1'b0;
    p0_ack = 1'b0;
    p1_ack = 1'b0;
    case (state_r)
      BUSY: begin
        mem_cs = 1'b1;
        mem_we = we_r;
      end
      DONE: begin
        p0_ack = (grant_r == PORT0);
        p1_ack = (grant_r == PORT1);
      end
      default: begin
        mem_cs = 1'b0;
        mem_we = 1'b0;
      end
    endcase
  end

  // Latch the winner's request at grant time and run the watchdog in BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      grant_r <= PORT0;
      wdog_r  <= 8'd0;
    end else if (grant_en_s) begin
      grant_r <= winner_s;
      wdog_r  <= 8'd0;
      if (winner_s == PORT1) begin
        we_r    <= p1_we;
        addr_r  <= p1_addr;
        wdata_r <= p1_wdata;
      end else begin
        we_r    <= p0_we;
        addr_r  <= p0_addr;
        wdata_r <= p0_wdata;
      end
    end else if ((state_r == BUSY) && !mem_ack && !wd_exp_s) begin
      wdog_r <= wdog_r + 8'd1;
    end
  end

  // Capture RAM data (or zero on abort) for the owner; remember any abort
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_r <= '0;
      rdata1_r <= '0;
      terr_r   <= 1'b0;
    end else if (state_r == BUSY) begin
      if (mem_ack) begin
        if (grant_r == PORT1) begin
          rdata1_r <= mem_dout;
        end else begin
          rdata0_r <= mem_dout;
        end
      end else if (wd_exp_s) begin
        terr_r <= 1'b1;
        if (grant_r == PORT1) begin
          rdata1_r <= '0;
        end else begin
          rdata0_r <= '0;
        end
      end
    end
  end

  assign mem_addr    = addr_r;
  assign mem_din     = wdata_r;
  assign grant       = grant_r;
  assign timeout_err = terr_r;
  assign p0_rdata    = rdata0_r;
  assign p1_rdata    = rdata1_r;
  assign p0_stall    = p0_req & ~p0_ack;
  assign p1_stall    = p1_req & ~p1_ack;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multi-cycle data RAM between two requesters: port 0 is the MEM-stage load/store, and port 1 is instruction fetch or a second master.
- Drives the RAM's cs/we/addr/din and holds them stable for the entire access, because the RAM only acks after the address has stayed constant for several cycles.
- Returns read data, a one-cycle ack and a combinational stall to each requester.
- Adds a watchdog so that a RAM which never acks cannot hang the pipeline.

Parameters:
- AW, 32: address width of the requester and RAM address buses.
- DW, 32: data width.
- TIMEOUT, 15: number of BUSY cycles without mem_ack before the access is aborted. Legal range 4..255.
- RR_EN, 1: 1 selects round-robin arbitration; 0 selects fixed priority with port 0 winning.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- p0_req  in  1  port 0 access request; held high until p0_ack.
- p0_we  in  1  port 0 write enable; 1 = write.
- p0_addr  in  AW  port 0 address.
- p0_wdata  in  DW  port 0 write data.
- p0_rdata  out  DW  port 0 read data.
- p0_ack  out  1  port 0 access complete; one-cycle pulse.
- p0_stall  out  1  port 0 stall, equal to p0_req & ~p0_ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_ack, p1_stall: same meaning for port 1.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_din  out  DW  RAM write data.
- mem_dout  in  DW  RAM read data.
- mem_ack  in  1  RAM access complete.
- grant  out  1  owner of the current or last access.
- timeout_err  out  1  sticky flag: an access was aborted by the watchdog.

Behaviour:
- States:
  - IDLE: examine requests; grant one or stay idle.
  - BUSY: RAM access in progress.
  - DONE: ack the owner; always returns to IDLE.
- Reset: state = IDLE and every output 0. That includes mem_* outputs, px_rdata, px_ack, grant and timeout_err. The round-robin pointer resets so that port 0 wins the first contention.
- Reset mid-access: the access is abandoned with no ack to the owner, and the arbiter returns to IDLE on the next edge.
- IDLE arbitration, at posedge:
  - If any req is high, latch the winner's we/addr/wdata into internal registers, set grant, go to BUSY, and clear the watchdog.
  - When both ports request: with RR_EN=1 the port not served last wins; with RR_EN=0 port 0 wins.
  - The round-robin pointer updates on every grant.
- mem_* outputs:
  - mem_cs = 1 only in BUSY.
  - mem_we/mem_addr/mem_din come from the latched registers. They are constant for the whole of BUSY, independent of later requester changes.
  - mem_we is 0 outside BUSY.
  - mem_addr/mem_din hold their last value outside BUSY so that the RAM address is not toggled needlessly.
- BUSY, at posedge:
  - If mem_ack = 1: capture mem_dout into the owner's rdata register (write accesses capture it as well) and go to DONE.
  - Otherwise, if the watchdog equals TIMEOUT-1: set timeout_err, load the owner's rdata with 0 and go to DONE (abort).
  - Otherwise: increment the watchdog.
- DONE:
  - The owner's px_ack = 1 for exactly this cycle; the other port's ack = 0.
  - px_rdata is valid in this cycle and holds until that port's next completion.
  - DONE goes to IDLE unconditionally. A requester that drops req at the DONE-ending edge is therefore never re-granted.
- Latency, request seen at edge T:
  - mem_cs rises after edge T.
  - With the RAM acking L cycles after mem_cs rises, px_ack is high in the cycle after edge T+L+1.
  - Minimum request-to-ack spacing is therefore L+2 cycles, plus one IDLE cycle before the next grant.
- Stall: px_stall = px_req & ~px_ack, purely combinational. A waiting port, including the loser of arbitration, stalls continuously.
- Back-to-back accesses to the same address need no special handling; the arbiter simply waits for mem_ack again.
- timeout_err clears only on rst.
- A requester that drops req before its ack is a protocol violation and the arbiter takes no action on it. The access still completes and acks.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding localparams: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - port id constants: PORT0=1'b0, PORT1=1'b1;
  - default TIMEOUT.
- One sub-module, arb_rr2: a two-way arbiter with a pointer register. Inputs req[1:0], update, rr_en; output the winner id. The FSM, watchdog and datapath registers stay in mem_arbiter.

Test Plan:
- Single read: p0 reads 0x00000004, RAM model acks L=4 with 0xDEADBEEF -> mem_addr = 0x00000004 stable all of BUSY; p0_ack is one pulse 6 cycles after the request; p0_rdata = 0xDEADBEEF; p0_stall high until the ack cycle.
- Contention RR_EN=1: p0 and p1 request together from reset, p0 0x8 and p1 0xC, then again -> order p0, p1, p0, p1. With RR_EN=0 -> p0 wins every time it requests.
- Write then read: p1 writes 0x12345678 to 0x10, then p0 reads 0x10 -> during p1's BUSY, mem_we = 1 and mem_din = 0x12345678; p0_rdata = 0x12345678.
- Address hold: change p0_addr during BUSY -> mem_addr unchanged until DONE; p1 waiting -> p1_stall = 1 throughout.
- Timeout: RAM never acks with TIMEOUT=15 -> the ack arrives after 15 BUSY cycles; rdata = 0; timeout_err = 1 and stays 1 across later good accesses until rst.
- Reset mid-BUSY: assert rst two cycles into an access -> next cycle state IDLE; mem_cs = 0, acks = 0, timeout_err = 0; no ack for the abandoned access.
